// File: rtl/mptw_fetch_queue_pkg.sv
// Shared MPT walker types: transaction layout, fault causes, MMPT mode encodings
// and the SPA zero-field masks used by the format check.
package mpt_pkg;

  typedef enum logic [1:0] {
    NO_ERROR       = 2'd0,
    NOT_VALID_ADDR = 2'd1,
    NOT_VALID_MPTE = 2'd2
  } page_format_fault_e;

  typedef enum logic {
    DO   = 1'b0,
    SKIP = 1'b1
  } walking_e;

  typedef struct packed {
    logic               valid;
    logic [3:0]         mmpt_mode;
    logic [63:0]        spa;
    walking_e           walking;
    page_format_fault_e format_error;
    logic               access_error;
    logic [7:0]         id;
  } mptw_transaction_t;

  typedef logic [2:0] mpt_mode_en_t;

  localparam logic [3:0] MODE_BARE    = 4'h0;
  localparam logic [3:0] MODE_SMMPT43 = 4'h1;
  localparam logic [3:0] MODE_SMMPT52 = 4'h2;
  localparam logic [3:0] MODE_SMMPT64 = 4'h3;

  localparam int MPT_FETCH_DEPTH_MAX = 16;

  // Bits above the physical address width that must be zero in each mode.
  localparam logic [63:0] SPA43_ZERO_MASK = 64'hFFFF_F800_0000_0000;
  localparam logic [63:0] SPA52_ZERO_MASK = 64'hFFF0_0000_0000_0000;

  function automatic logic is_fault(input page_format_fault_e f);
    return f != NO_ERROR;
  endfunction

endpackage

// File: rtl/mptw_fetch_queue_if.sv
// Valid/ready stage link carrying a packed walker transaction.
interface mptw_fetch_queue_if
  import mpt_pkg::*;
#(
  parameter int DATA_WIDTH = $bits(mptw_transaction_t)
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/mptw_fetch_queue_format_check.sv
// Combinational SPA format check of an incoming walker transaction against the
// MMPT mode and the set of enabled modes.
module mpt_format_check
  import mpt_pkg::*;
#(
  parameter mpt_mode_en_t MODE_EN = 3'b111
) (
  input  logic [3:0]         mmpt_i,
  input  logic [63:0]        spa_i,
  input  logic               valid_i,
  output page_format_fault_e fault_o
);

  // Classify the address; invalid beats are never faulted.
  always_comb begin
    fault_o = NO_ERROR;
    if (valid_i) begin
      case (mmpt_i)
        MODE_BARE:    fault_o = NOT_VALID_ADDR;
        MODE_SMMPT43: fault_o = (((spa_i & SPA43_ZERO_MASK) != 64'd0) || !MODE_EN[0])
                                ? NOT_VALID_ADDR : NO_ERROR;
        MODE_SMMPT52: fault_o = (((spa_i & SPA52_ZERO_MASK) != 64'd0) || !MODE_EN[1])
                                ? NOT_VALID_ADDR : NO_ERROR;
        MODE_SMMPT64: fault_o = MODE_EN[2] ? NO_ERROR : NOT_VALID_ADDR;
        default:      fault_o = NOT_VALID_ADDR;
      endcase
    end else begin
      fault_o = NO_ERROR;
    end
  end

endmodule

// File: rtl/mptw_fetch_queue.sv
// MPT walker fetch stage: format-checks and annotates incoming transactions,
// buffers them in a DEPTH-entry FIFO, and reports faults as a pulse plus a counter.
module mptw_fetch_queue
  import mpt_pkg::*;
#(
  parameter int           DATA_WIDTH = $bits(mptw_transaction_t),
  parameter int           DEPTH      = 2,
  parameter mpt_mode_en_t MODE_EN    = 3'b111,
  parameter int           CNT_WIDTH  = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  mptw_fetch_queue_if.slave         stage_slave,
  mptw_fetch_queue_if.master        stage_master,
  input  logic                      flush_i,
  input  logic                      cnt_clear_i,
  output logic                      exception_valid_o,
  output page_format_fault_e        exception_cause_o,
  output logic [$clog2(DEPTH):0]    occupancy_o,
  output logic [CNT_WIDTH-1:0]      fault_count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  if (DATA_WIDTH != $bits(mptw_transaction_t)) begin : g_bad_width
    $error("mptw_fetch_queue: DATA_WIDTH must equal $bits(mptw_transaction_t)");
  end
  if (DEPTH < 2 || DEPTH > MPT_FETCH_DEPTH_MAX || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("mptw_fetch_queue: DEPTH must be a power of two in 2..16");
  end

  mptw_transaction_t  r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [OCC_W-1:0]   r_occ;
  logic               r_exc_valid;
  page_format_fault_e r_exc_cause;
  logic [CNT_WIDTH-1:0] r_cnt;

  mptw_transaction_t  w_in;
  mptw_transaction_t  w_ann;
  page_format_fault_e w_fault;
  logic               w_ready;
  logic               w_push;
  logic               w_pop;
  logic               w_fault_push;

  assign w_in         = mptw_transaction_t'(stage_slave.data);
  assign w_ready      = r_occ < OCC_W'(DEPTH);
  assign w_push       = stage_slave.valid & w_ready & !flush_i;
  assign w_pop        = (r_occ != OCC_W'(0)) & stage_master.ready;
  assign w_fault_push = w_push & is_fault(w_fault);

  mpt_format_check #(.MODE_EN(MODE_EN)) u_format_check (
    .mmpt_i  (w_in.mmpt_mode),
    .spa_i   (w_in.spa),
    .valid_i (w_in.valid),
    .fault_o (w_fault)
  );

  // Overwrite the walker-owned fields; an invalid beat carries no error state.
  always_comb begin
    w_ann              = w_in;
    w_ann.walking      = is_fault(w_fault) ? SKIP : DO;
    w_ann.format_error = w_in.valid ? w_fault : NO_ERROR;
    if (w_in.valid) begin
      w_ann.access_error = w_in.access_error;
    end else begin
      w_ann.access_error = 1'b0;
    end
  end

  // Storage array; contents are qualified by occupancy so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= w_ann;
  end

  // Pointers and occupancy; flush empties the queue but lets a same-cycle pop complete.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Exception pulse and held cause, plus the saturating fault counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_exc_valid <= 1'b0;
      r_exc_cause <= NO_ERROR;
      r_cnt       <= '0;
    end else begin
      r_exc_valid <= w_fault_push;
      if (w_fault_push) r_exc_cause <= w_fault;
      if (cnt_clear_i) begin
        r_cnt <= '0;
      end else if (w_fault_push && r_cnt != {CNT_WIDTH{1'b1}}) begin
        r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign stage_slave.ready  = w_ready;
  assign stage_master.valid = r_occ != OCC_W'(0);
  assign stage_master.data  = DATA_WIDTH'(r_mem[r_rd_ptr]);
  assign exception_valid_o  = r_exc_valid;
  assign exception_cause_o  = r_exc_cause;
  assign occupancy_o        = r_occ;
  assign fault_count_o      = r_cnt;

endmodule

// File: tb/tb_mptw_fetch_queue.sv
// Directed bench: instance A (DEPTH=4, all modes) and instance B
// (DEPTH=2, SMMPT64 disabled, 2-bit counter).
module tb_mptw_fetch_queue;
  import mpt_pkg::*;

  localparam int DW = $bits(mptw_transaction_t);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  logic rst_a, flush_a, clr_a, exc_a;
  logic rst_b, flush_b, clr_b, exc_b;
  page_format_fault_e cause_a, cause_b;
  logic [2:0]  occ_a;
  logic [1:0]  occ_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  mptw_fetch_queue_if #(.DATA_WIDTH(DW)) a_in ();
  mptw_fetch_queue_if #(.DATA_WIDTH(DW)) a_out ();
  mptw_fetch_queue_if #(.DATA_WIDTH(DW)) b_in ();
  mptw_fetch_queue_if #(.DATA_WIDTH(DW)) b_out ();

  mptw_transaction_t a_head, b_head;
  assign a_head = mptw_transaction_t'(a_out.data);
  assign b_head = mptw_transaction_t'(b_out.data);

  mptw_fetch_queue #(.DATA_WIDTH(DW), .DEPTH(4), .MODE_EN(3'b111), .CNT_WIDTH(16)) dut_a (
    .clk_i(clk), .rst_i(rst_a), .stage_slave(a_in), .stage_master(a_out),
    .flush_i(flush_a), .cnt_clear_i(clr_a), .exception_valid_o(exc_a),
    .exception_cause_o(cause_a), .occupancy_o(occ_a), .fault_count_o(cnt_a)
  );

  mptw_fetch_queue #(.DATA_WIDTH(DW), .DEPTH(2), .MODE_EN(3'b011), .CNT_WIDTH(2)) dut_b (
    .clk_i(clk), .rst_i(rst_b), .stage_slave(b_in), .stage_master(b_out),
    .flush_i(flush_b), .cnt_clear_i(clr_b), .exception_valid_o(exc_b),
    .exception_cause_o(cause_b), .occupancy_o(occ_b), .fault_count_o(cnt_b)
  );

  // Walker-owned fields are preloaded with junk so the annotation must overwrite them.
  function automatic logic [DW-1:0] mk(input logic v, input logic [3:0] mode,
                                       input logic [63:0] spa, input logic acc,
                                       input logic [7:0] id);
    mptw_transaction_t t;
    t.valid = v; t.mmpt_mode = mode; t.spa = spa; t.walking = SKIP;
    t.format_error = NOT_VALID_MPTE; t.access_error = acc; t.id = id;
    return DW'(t);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1;
    flush_a = 1'b0; clr_a = 1'b0; flush_b = 1'b0; clr_b = 1'b0;
    a_in.valid = 1'b0; a_in.data = '0; a_out.ready = 1'b0;
    b_in.valid = 1'b0; b_in.data = '0; b_out.ready = 1'b0;
    tick(); tick();
    rst_a = 1'b0; rst_b = 1'b0;
    n_total++; if (a_out.valid !== 1'b0) $display("FAIL reset_mvalid: got %0b want 0", a_out.valid); else n_pass++;
    n_total++; if (occ_a !== 3'd0) $display("FAIL reset_occ: got %0d want 0", occ_a); else n_pass++;
    n_total++; if (a_in.ready !== 1'b1) $display("FAIL reset_ready: got %0b want 1", a_in.ready); else n_pass++;
    n_total++; if (exc_a !== 1'b0 || cause_a !== NO_ERROR) $display("FAIL reset_exc: got %0b/%0d want 0/0", exc_a, cause_a); else n_pass++;
    n_total++; if (cnt_a !== 16'd0 || cnt_b !== 2'd0) $display("FAIL reset_cnt: got %0d/%0d want 0/0", cnt_a, cnt_b); else n_pass++;
  endtask

  task automatic test_basic();
    a_out.ready = 1'b1;
    a_in.valid = 1'b1; a_in.data = mk(1'b1, MODE_SMMPT43, 64'h0000_0000_0000_1000, 1'b1, 8'd1);
    tick();
    a_in.valid = 1'b0;
    n_total++; if (a_out.valid !== 1'b1 || a_head.id !== 8'd1) $display("FAIL basic_head: got v=%0b id=%0d want v=1 id=1", a_out.valid, a_head.id); else n_pass++;
    n_total++; if (a_head.walking !== DO || a_head.format_error !== NO_ERROR) $display("FAIL basic_annot: got %0d/%0d want 0/0", a_head.walking, a_head.format_error); else n_pass++;
    n_total++; if (a_head.access_error !== 1'b1 || exc_a !== 1'b0) $display("FAIL basic_acc_exc: got %0b/%0b want 1/0", a_head.access_error, exc_a); else n_pass++;
    tick();
    n_total++; if (a_out.valid !== 1'b0 || occ_a !== 3'd0) $display("FAIL basic_drain: got v=%0b occ=%0d want 0/0", a_out.valid, occ_a); else n_pass++;
  endtask

  task automatic test_faults();
    a_out.ready = 1'b1;
    a_in.valid = 1'b1; a_in.data = mk(1'b1, MODE_SMMPT52, 64'h0010_0000_0000_0000, 1'b0, 8'd2);
    tick();
    n_total++; if (exc_a !== 1'b1 || cause_a !== NOT_VALID_ADDR) $display("FAIL fault52_exc: got %0b/%0d want 1/1", exc_a, cause_a); else n_pass++;
    n_total++; if (a_head.walking !== SKIP || a_head.format_error !== NOT_VALID_ADDR) $display("FAIL fault52_annot: got %0d/%0d want 1/1", a_head.walking, a_head.format_error); else n_pass++;
    a_in.data = mk(1'b1, MODE_BARE, 64'h0, 1'b0, 8'd3);
    tick();
    n_total++; if (exc_a !== 1'b1 || a_head.id !== 8'd3 || occ_a !== 3'd1) $display("FAIL faultbare: got exc=%0b id=%0d occ=%0d want 1/3/1", exc_a, a_head.id, occ_a); else n_pass++;
    a_in.data = mk(1'b1, 4'hF, 64'h0, 1'b0, 8'd4);
    tick();
    n_total++; if (exc_a !== 1'b1 || a_head.walking !== SKIP || a_head.id !== 8'd4) $display("FAIL faultrsv: got exc=%0b walk=%0d id=%0d want 1/1/4", exc_a, a_head.walking, a_head.id); else n_pass++;
    a_in.valid = 1'b0;
    tick();
    n_total++; if (exc_a !== 1'b0 || cause_a !== NOT_VALID_ADDR) $display("FAIL fault_pulse_end: got %0b/%0d want 0/1", exc_a, cause_a); else n_pass++;
    n_total++; if (cnt_a !== 16'd3) $display("FAIL fault_count: got %0d want 3", cnt_a); else n_pass++;
  endtask

  task automatic test_full();
    a_out.ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_in.valid = 1'b1; a_in.data = mk(1'b1, MODE_SMMPT64, 64'hDEAD_0000, 1'b0, 8'(11 + i));
      n_total++; if (a_in.ready !== 1'b1) $display("FAIL full_ready_%0d: got 0 want 1", i); else n_pass++;
      tick();
    end
    n_total++; if (occ_a !== 3'd4 || a_in.ready !== 1'b0) $display("FAIL full_state: got occ=%0d rdy=%0b want 4/0", occ_a, a_in.ready); else n_pass++;
    a_in.data = mk(1'b1, MODE_SMMPT64, 64'hDEAD_0000, 1'b0, 8'd15);
    tick();
    n_total++; if (occ_a !== 3'd4 || a_head.id !== 8'd11) $display("FAIL full_hold: got occ=%0d id=%0d want 4/11", occ_a, a_head.id); else n_pass++;
    a_out.ready = 1'b1;
    tick();
    n_total++; if (occ_a !== 3'd3 || a_in.ready !== 1'b1 || a_head.id !== 8'd12) $display("FAIL full_pop: got occ=%0d rdy=%0b id=%0d want 3/1/12", occ_a, a_in.ready, a_head.id); else n_pass++;
    a_out.ready = 1'b0;
    tick();
    n_total++; if (occ_a !== 3'd4) $display("FAIL full_fifth: got occ=%0d want 4", occ_a); else n_pass++;
    a_in.valid = 1'b0; a_out.ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_total++; if (a_head.id !== 8'(12 + k)) $display("FAIL full_order_%0d: got id=%0d want %0d", k, a_head.id, 12 + k); else n_pass++;
      tick();
    end
    n_total++; if (occ_a !== 3'd0 || a_out.valid !== 1'b0) $display("FAIL full_empty: got occ=%0d v=%0b want 0/0", occ_a, a_out.valid); else n_pass++;
  endtask

  task automatic test_flush();
    a_out.ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_in.valid = 1'b1; a_in.data = mk(1'b1, MODE_SMMPT64, 64'h0, 1'b0, 8'(21 + i));
      tick();
    end
    a_in.data = mk(1'b1, MODE_BARE, 64'h0, 1'b0, 8'd24);
    flush_a = 1'b1;
    n_total++; if (occ_a !== 3'd3) $display("FAIL flush_pre_occ: got %0d want 3", occ_a); else n_pass++;
    tick();
    flush_a = 1'b0; a_in.valid = 1'b0;
    n_total++; if (occ_a !== 3'd0 || a_out.valid !== 1'b0) $display("FAIL flush_empty: got occ=%0d v=%0b want 0/0", occ_a, a_out.valid); else n_pass++;
    n_total++; if (exc_a !== 1'b0 || cnt_a !== 16'd3) $display("FAIL flush_exc_cnt: got %0b/%0d want 0/3", exc_a, cnt_a); else n_pass++;
  endtask

  task automatic test_reset_mid();
    a_out.ready = 1'b0;
    a_in.valid = 1'b1; a_in.data = mk(1'b1, MODE_SMMPT64, 64'h0, 1'b0, 8'd41);
    tick(); tick();
    a_in.valid = 1'b0; rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    n_total++; if (occ_a !== 3'd0 || a_out.valid !== 1'b0 || cnt_a !== 16'd0) $display("FAIL midreset: got occ=%0d v=%0b cnt=%0d want 0/0/0", occ_a, a_out.valid, cnt_a); else n_pass++;
  endtask

  task automatic test_mode_en();
    b_out.ready = 1'b1;
    b_in.valid = 1'b1; b_in.data = mk(1'b1, MODE_SMMPT64, 64'h1234, 1'b0, 8'd31);
    tick();
    n_total++; if (b_head.format_error !== NOT_VALID_ADDR || b_head.walking !== SKIP || exc_b !== 1'b1) $display("FAIL modeen64: got fe=%0d walk=%0d exc=%0b want 1/1/1", b_head.format_error, b_head.walking, exc_b); else n_pass++;
    b_in.data = mk(1'b0, MODE_BARE, 64'h0, 1'b1, 8'd32);
    tick();
    n_total++; if (b_head.id !== 8'd32 || b_head.format_error !== NO_ERROR || b_head.access_error !== 1'b0) $display("FAIL invalid_annot: got id=%0d fe=%0d acc=%0b want 32/0/0", b_head.id, b_head.format_error, b_head.access_error); else n_pass++;
    n_total++; if (b_head.walking !== DO || exc_b !== 1'b0 || cnt_b !== 2'd1) $display("FAIL invalid_exc: got walk=%0d exc=%0b cnt=%0d want 0/0/1", b_head.walking, exc_b, cnt_b); else n_pass++;
    b_in.data = mk(1'b1, MODE_SMMPT43, 64'h0000_0800_0000_0000, 1'b0, 8'd33);
    tick();
    n_total++; if (exc_b !== 1'b1 || b_head.format_error !== NOT_VALID_ADDR) $display("FAIL zero43: got exc=%0b fe=%0d want 1/1", exc_b, b_head.format_error); else n_pass++;
    b_in.data = mk(1'b1, MODE_SMMPT43, 64'h0000_07FF_FFFF_FFFF, 1'b0, 8'd34);
    tick();
    n_total++; if (exc_b !== 1'b0 || b_head.walking !== DO || cnt_b !== 2'd2) $display("FAIL ok43: got exc=%0b walk=%0d cnt=%0d want 0/0/2", exc_b, b_head.walking, cnt_b); else n_pass++;
  endtask

  task automatic test_saturate();
    b_out.ready = 1'b1;
    b_in.valid = 1'b1; b_in.data = mk(1'b1, MODE_BARE, 64'h0, 1'b0, 8'd50);
    for (int k = 0; k < 3; k++) begin
      tick();
      n_total++; if (cnt_b !== 2'd3) $display("FAIL sat_%0d: got %0d want 3", k, cnt_b); else n_pass++;
    end
    clr_b = 1'b1;
    tick();
    n_total++; if (cnt_b !== 2'd0 || exc_b !== 1'b1) $display("FAIL clr_prio: got cnt=%0d exc=%0b want 0/1", cnt_b, exc_b); else n_pass++;
    clr_b = 1'b0; b_in.valid = 1'b0;
    tick();
    n_total++; if (cnt_b !== 2'd0 || exc_b !== 1'b0) $display("FAIL clr_hold: got cnt=%0d exc=%0b want 0/0", cnt_b, exc_b); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_faults();
    test_full();
    test_flush();
    test_reset_mid();
    test_mode_en();
    test_saturate();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
